// File: rtl/lcd_scanout.sv
// Read-side scan-out engine: raster timing, front-buffer read addressing,
// sync-aligned pixel forwarding and the frame-end buffer-swap handshake.
module lcd_scanout #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 43,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 12,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic [ADDR_W-1:0] fb_rad,
    input  logic [7:0]        fb_dout,
    output logic              switch,
    output logic              lcd_hsync,
    output logic              lcd_vsync,
    output logic              lcd_de,
    output logic [7:0]        lcd_data
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [ADDR_W-1:0] RAD_MAX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ACK     = 2'd2
    } swap_state_t;

    logic [HW-1:0]     h_r;
    logic [VW-1:0]     v_r;
    logic [ADDR_W-1:0] fb_rad_r;
    logic              hsync_r;
    logic              vsync_r;
    logic              de_r;
    logic              req_meta_r;
    logic              req_sync_r;
    swap_state_t       state_r;
    logic              switch_r;
    logic              swap_ack_r;

    logic              h_wrap_s;
    logic              v_wrap_s;
    logic              active_s;
    logic              hsync_s;
    logic              vsync_s;
    logic              swap_point_s;
    logic [7:0]        data_s;

    // Decode the current counter position into region and sync flags.
    // The swap point is looked at one cycle early so the registered strobe
    // is high exactly while the counters sit at h == 0, v == V_ACTIVE.
    always_comb begin
        h_wrap_s     = (h_r == H_LAST);
        v_wrap_s     = (v_r == V_LAST);
        active_s     = (h_r < H_ACT) && (v_r < V_ACT);
        hsync_s      = (h_r >= HS_BEG) && (h_r < HS_END);
        vsync_s      = (v_r >= VS_BEG) && (v_r < VS_END);
        swap_point_s = h_wrap_s && (v_r == V_ACT_LAST);
    end

    // Horizontal and vertical raster counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_r <= {HW{1'b0}};
            v_r <= {VW{1'b0}};
        end else if (h_wrap_s) begin
            h_r <= {HW{1'b0}};
            if (v_wrap_s) begin
                v_r <= {VW{1'b0}};
            end else begin
                v_r <= v_r + 1'b1;
            end
        end else begin
            h_r <= h_r + 1'b1;
        end
    end

    // Running read address; holds at the last pixel so it never wraps mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_rad_r <= {ADDR_W{1'b0}};
        end else if (v_r == V_ACT) begin
            fb_rad_r <= {ADDR_W{1'b0}};
        end else if (active_s && (fb_rad_r != RAD_MAX)) begin
            fb_rad_r <= fb_rad_r + 1'b1;
        end else begin
            fb_rad_r <= fb_rad_r;
        end
    end

    // Panel controls delayed one stage to line up with the read data latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_r <= 1'b1;
            vsync_r <= 1'b1;
            de_r    <= 1'b0;
        end else begin
            hsync_r <= ~hsync_s;
            vsync_r <= ~vsync_s;
            de_r    <= active_s;
        end
    end

    // Blank pixel data outside the visible area.
    always_comb begin
        if (de_r) begin
            data_s = fb_dout;
        end else begin
            data_s = 8'h00;
        end
    end

    // Two-flop synchronizer for the writer-domain request level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_meta_r <= 1'b0;
            req_sync_r <= 1'b0;
        end else begin
            req_meta_r <= swap_req;
            req_sync_r <= req_meta_r;
        end
    end

    // Swap handshake FSM; a cancelled request wins over a coincident swap point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            switch_r   <= 1'b0;
            swap_ack_r <= 1'b0;
        end else begin
            switch_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_sync_r) begin
                        state_r <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (!req_sync_r) begin
                        state_r <= ST_IDLE;
                    end else if (swap_point_s) begin
                        state_r    <= ST_ACK;
                        switch_r   <= 1'b1;
                        swap_ack_r <= 1'b1;
                    end
                end
                ST_ACK: begin
                    if (!req_sync_r) begin
                        state_r    <= ST_IDLE;
                        swap_ack_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    swap_ack_r <= 1'b0;
                end
            endcase
        end
    end

    assign fb_rad    = fb_rad_r;
    assign lcd_hsync = hsync_r;
    assign lcd_vsync = vsync_r;
    assign lcd_de    = de_r;
    assign lcd_data  = data_s;
    assign switch    = switch_r;
    assign swap_ack  = swap_ack_r;

endmodule

// File: tb/tb_lcd_scanout.sv
// Self-checking bench for lcd_scanout: raster/data expectations from cycle
// arithmetic, swap behaviour from a rule-level handshake model.
module tb_lcd_scanout;

    localparam int HA = 4, HFP = 1, HS = 2, HBP = 1;
    localparam int VA = 3, VFP = 1, VS = 1, VBP = 1;
    localparam int AW = 16;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          swap_req = 1'b0;
    logic [7:0]    fb_dout  = 8'h00;
    logic [7:0]    data_ofs = 8'h10;
    logic          swap_ack;
    logic [AW-1:0] fb_rad;
    logic          sw;
    logic          lcd_hsync;
    logic          lcd_vsync;
    logic          lcd_de;
    logic [7:0]    lcd_data;

    lcd_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .swap_req(swap_req),
        .swap_ack(swap_ack),
        .fb_rad(fb_rad),
        .fb_dout(fb_dout),
        .switch(sw),
        .lcd_hsync(lcd_hsync),
        .lcd_vsync(lcd_vsync),
        .lcd_de(lcd_de),
        .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    // Framebuffer read port with one cycle of registered latency.
    always @(posedge clk) fb_dout <= fb_rad[7:0] + data_ofs;

    int n_checks = 0;
    int n_fail   = 0;

    // Handshake model state and per-run observations.
    bit m_pend, m_acked, m_switch;
    bit q1, q2;
    int pulses;
    int first_sw;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_rad(input int h, input int v);
        int n;
        if (v < VA) begin
            n = v * HA + ((h < HA) ? h : HA);
            return (n > HA * VA - 1) ? HA * VA - 1 : n;
        end else if (v == VA && h == 0) begin
            return HA * VA - 1;
        end
        return 0;
    endfunction

    task automatic check_reset(input string tag);
        check_eq({tag, "_hsync"}, lcd_hsync, 1);
        check_eq({tag, "_vsync"}, lcd_vsync, 1);
        check_eq({tag, "_de"}, lcd_de, 0);
        check_eq({tag, "_data"}, lcd_data, 0);
        check_eq({tag, "_switch"}, sw, 0);
        check_eq({tag, "_ack"}, swap_ack, 0);
        check_eq({tag, "_rad"}, fb_rad, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        swap_req = 1'b0;
        #1;
        check_reset("rst");
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        q1       = 1'b0;
        q2       = 1'b0;
        m_pend   = 1'b0;
        m_acked  = 1'b0;
        m_switch = 1'b0;
        pulses   = 0;
        first_sw = -1;
        #1;
    endtask

    // Compare cycle k against the reference, then advance the model and drive stimulus.
    task automatic step(input int k, input int rise, input int fall, input bit rnd);
        int  h, v, hp, vp;
        bit  e_de, e_hs, e_vs, rs, look;
        logic [7:0] e_data;
        h = k % HT;
        v = (k / HT) % VT;
        if (k == 0) begin
            e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_data = 8'h00;
        end else begin
            hp = (k - 1) % HT;
            vp = ((k - 1) / HT) % VT;
            e_de   = (hp < HA) && (vp < VA);
            e_hs   = !((hp >= HA + HFP) && (hp < HA + HFP + HS));
            e_vs   = !((vp >= VA + VFP) && (vp < VA + VFP + VS));
            e_data = e_de ? 8'(vp * HA + hp) + data_ofs : 8'h00;
        end
        check_eq("de", lcd_de, e_de);
        check_eq("hsync", lcd_hsync, e_hs);
        check_eq("vsync", lcd_vsync, e_vs);
        check_eq("data", lcd_data, e_data);
        check_eq("rad", fb_rad, exp_rad(h, v));
        check_eq("switch", sw, m_switch);
        check_eq("ack", swap_ack, m_acked);
        if (sw === 1'b1) begin
            pulses++;
            if (first_sw < 0) first_sw = k;
        end

        rs       = q2;
        look     = (h == HT - 1) && (v == VA - 1);
        m_switch = 1'b0;
        if (m_acked) begin
            if (!rs) m_acked = 1'b0;
        end else if (m_pend) begin
            if (!rs) begin
                m_pend = 1'b0;
            end else if (look) begin
                m_pend   = 1'b0;
                m_acked  = 1'b1;
                m_switch = 1'b1;
            end
        end else if (rs) begin
            m_pend = 1'b1;
        end

        if (rnd) begin
            if ($urandom_range(0, 29) == 0) swap_req = ~swap_req;
        end else begin
            swap_req = (k >= rise) && (k < fall);
        end
        q2 = q1;
        q1 = swap_req;
    endtask

    task automatic run(input int rise, input int fall, input bit rnd, input int ncyc, input int rst_at);
        apply_reset();
        for (int k = 0; k < ncyc; k++) begin
            if (k == rst_at) begin
                rst_n    = 1'b0;
                swap_req = 1'b0;
                #1;
                check_reset("midrst");
                return;
            end
            step(k, rise, fall, rnd);
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        data_ofs = 8'h10;
        run(5, 30, 1'b0, 200, -1);
        check_eq("swap_pulses", pulses, 1);
        check_eq("swap_cycle", first_sw, 24);

        run(2, 10, 1'b0, 100, -1);
        check_eq("cancel_pulses", pulses, 0);

        run(0, 5 * HT * VT, 1'b0, 6 * HT * VT + 10, -1);
        check_eq("held_pulses", pulses, 1);

        run(5, 1000, 1'b0, 100, 18);
        run(1000, 1000, 1'b0, 100, -1);
        check_eq("postrst_pulses", pulses, 0);

        for (int i = 0; i < 4; i++) begin
            data_ofs = 8'($urandom_range(0, 255));
            run(0, 0, 1'b1, 700, (i % 2 == 1) ? int'($urandom_range(50, 600)) : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
